// File: rtl/system_bus_pkg.sv
// Shared definitions for the serial system bus.
//   slave_state_t  : bus_slave FSM states (encoding is visible on state_show)
//   BUS_*/SLAVE_*  : bus-level address/data widths
//   MODE_*         : value of the leading mode bit of a transaction
//   max3()         : elaboration-time helper for sizing counters
package system_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_WRITE = 3'd3,
    S_RWAIT = 3'd4,
    S_RDATA = 3'd5
  } slave_state_t;

  localparam int BUS_ADDR_WIDTH   = 16;
  localparam int SLAVE_ADDR_WIDTH = 12;
  localparam int BUS_DATA_WIDTH   = 8;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bus_slave_if.sv
// Serial bus link between a granted master and one slave.
//   bus_valid   : master -> slave, high for the whole transaction
//   bus_wdata   : master -> slave, serial mode/address/write-data line
//   slave_ready : slave -> master, slave is idle and can accept
//   bus_rdata   : slave -> master, serial read data, LSB-first
//   bus_rvalid  : slave -> master, qualifies each read data bit
interface bus_slave_if;

  logic bus_valid;
  logic bus_wdata;
  logic slave_ready;
  logic bus_rdata;
  logic bus_rvalid;

  modport master (
    output bus_valid,
    output bus_wdata,
    input  slave_ready,
    input  bus_rdata,
    input  bus_rvalid
  );

  modport slave (
    input  bus_valid,
    input  bus_wdata,
    output slave_ready,
    output bus_rdata,
    output bus_rvalid
  );

endinterface

// File: rtl/bus_slave_mem.sv
// Single-port RAM: synchronous write, registered read (read-before-write).
//   clk   : clock
//   we    : write enable
//   addr  : word address, shared by read and write
//   wdata : write data
//   rdata : registered read data of addr from the previous edge
// Contents are not reset.
module bus_slave_mem #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_slave.sv
// Serial bus slave: deserialises mode bit, local address (LSB-first) and,
// for writes, a data word (LSB-first); writes it to local memory or returns
// the addressed word serially after READ_LATENCY wait cycles.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset of the control path
//   bus        : slave side of the serial bus (valid/wdata in, ready/rdata/rvalid out)
//   state_show : current FSM state for debug
// All outputs decode the state register and the read shift register only.
module bus_slave
  import system_bus_pkg::*;
#(
  parameter int ADDR_WIDTH   = SLAVE_ADDR_WIDTH,
  parameter int DATA_WIDTH   = BUS_DATA_WIDTH,
  parameter int MEM_DEPTH    = 2048,
  parameter int READ_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  bus_slave_if.slave       bus,
  output logic [2:0]       state_show
);

  localparam int CNT_W  = $clog2(max3(ADDR_WIDTH, DATA_WIDTH, READ_LATENCY)) + 1;
  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam int AIDX_W = (MEM_AW > 1) ? $clog2(MEM_AW) : 1;
  localparam int DIDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  slave_state_t state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             mode_q;

  logic mode_load, addr_shift, data_shift, sh_load, sh_shift, mem_we;

  // Only the address bits that index memory are kept; higher local bits alias.
  logic [MEM_AW-1:0]     addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] rd_data;

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_READ;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      if (mode_load) begin
        mode_q <= bus.bus_wdata;
      end
    end
  end

  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    mode_load  = 1'b0;
    addr_shift = 1'b0;
    data_shift = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    mem_we     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.bus_valid) begin
          mode_load = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (!bus.bus_valid) begin
          state_nxt = S_IDLE;
        end else begin
          addr_shift = 1'b1;
          if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
            cnt_nxt   = '0;
            state_nxt = (mode_q == MODE_WRITE) ? S_WDATA : S_RWAIT;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
      end
      S_WDATA: begin
        if (!bus.bus_valid) begin
          state_nxt = S_IDLE;
        end else begin
          data_shift = 1'b1;
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            cnt_nxt   = '0;
            state_nxt = S_WRITE;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
      end
      // Atomic: the write happens regardless of bus_valid.
      S_WRITE: begin
        mem_we    = 1'b1;
        state_nxt = S_IDLE;
      end
      S_RWAIT: begin
        if (!bus.bus_valid) begin
          state_nxt = S_IDLE;
        end else if (cnt_q == CNT_W'(READ_LATENCY - 1)) begin
          sh_load   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_RDATA;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      S_RDATA: begin
        if (!bus.bus_valid) begin
          state_nxt = S_IDLE;
        end else begin
          sh_shift = 1'b1;
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // The RAM is driven with the address the register is about to hold, so the
  // registered read already reflects the final address bit one cycle after
  // it arrives; this keeps READ_LATENCY=1 correct.
  always_comb begin
    addr_nxt = addr_q;
    if (addr_shift && (cnt_q < CNT_W'(MEM_AW))) begin
      addr_nxt[cnt_q[AIDX_W-1:0]] = bus.bus_wdata;
    end
  end

  // Data path registers (not reset)
  always_ff @(posedge clk) begin
    addr_q <= addr_nxt;
    if (data_shift) begin
      data_q[cnt_q[DIDX_W-1:0]] <= bus.bus_wdata;
    end
    if (sh_load) begin
      shreg_q <= rd_data;
    end else if (sh_shift) begin
      shreg_q <= {1'b0, shreg_q[DATA_WIDTH-1:1]};
    end
  end

  bus_slave_mem #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_nxt),
    .wdata (data_q),
    .rdata (rd_data)
  );

  // Gating rdata with the state keeps the line at 0 immediately on reset or
  // abort, even though the shift register itself is not reset.
  assign bus.slave_ready = (state_q == S_IDLE);
  assign bus.bus_rvalid  = (state_q == S_RDATA);
  assign bus.bus_rdata   = (state_q == S_RDATA) & shreg_q[0];
  assign state_show      = state_q;

endmodule

// File: tb/tb_bus_slave.sv
module tb_bus_slave;
  import system_bus_pkg::*;

  logic       clk;
  logic       rst;
  logic [2:0] state_show;

  bus_slave_if bif();

  bus_slave #(
    .ADDR_WIDTH   (12),
    .DATA_WIDTH   (8),
    .MEM_DEPTH    (2048),
    .READ_LATENCY (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bif),
    .state_show (state_show)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bif.bus_valid = 1'b1;
    bif.bus_wdata = b;
    tick();
  endtask

  task automatic send_addr(input logic [11:0] a);
    for (int i = 0; i < 12; i++) send_bit(a[i]);
  endtask

  task automatic send_data(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  // Full write; returns one cycle after WRITE (slave back in IDLE).
  task automatic write_word(input logic [11:0] a, input logic [7:0] d);
    send_bit(1'b1);
    send_addr(a);
    send_data(d);
    bif.bus_valid = 1'b0;
    bif.bus_wdata = 1'b0;
    tick();
  endtask

  // Called at the first RWAIT cycle (T+13). Offsets are relative to it.
  // Valid is dropped as soon as IDLE is seen so no new transaction starts.
  task automatic read_collect(output logic [7:0] d, output int nbits,
                              output int first, output int idle_at);
    d = '0; nbits = 0; first = -1; idle_at = -1;
    bif.bus_wdata = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (state_show == 3'd0) begin
        bif.bus_valid = 1'b0;
        idle_at = k;
        break;
      end
      if (bif.bus_rvalid) begin
        if (first < 0) first = k;
        if (nbits < 8) d[nbits] = bif.bus_rdata;
        nbits++;
      end
      tick();
    end
    bif.bus_valid = 1'b0;
    tick();
  endtask

  task automatic read_word(input logic [11:0] a, output logic [7:0] d,
                           output int nbits, output int first, output int idle_at);
    send_bit(1'b0);
    send_addr(a);
    read_collect(d, nbits, first, idle_at);
  endtask

  task automatic test_reset();
    rst = 1'b1; bif.bus_valid = 1'b0; bif.bus_wdata = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++; if (bif.slave_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bif.slave_ready); end
    n_checks++; if (bif.bus_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", bif.bus_rvalid); end
    n_checks++; if (bif.bus_rdata !== 1'b0) begin n_fail++; $display("FAIL reset_rdata got %b want 0", bif.bus_rdata); end
    n_checks++; if (state_show !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_show); end
    tick(); tick(); tick();
    n_checks++; if (state_show !== 3'd0) begin n_fail++; $display("FAIL idle_hold_state got %0d want 0", state_show); end
    n_checks++; if (bif.slave_ready !== 1'b1) begin n_fail++; $display("FAIL idle_hold_ready got %b want 1", bif.slave_ready); end
  endtask

  task automatic test_write_read();
    logic [7:0] d; int nb, fi, ia;
    send_bit(1'b1);
    send_addr(12'h001);
    send_data(8'h55);
    // T+21: WRITE; drop valid to show the write still completes.
    n_checks++; if (state_show !== 3'd3) begin n_fail++; $display("FAIL wr_state_t21 got %0d want 3", state_show); end
    n_checks++; if (bif.slave_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready_t21 got %b want 0", bif.slave_ready); end
    bif.bus_valid = 1'b0;
    tick();
    n_checks++; if (state_show !== 3'd0) begin n_fail++; $display("FAIL wr_state_t22 got %0d want 0", state_show); end
    n_checks++; if (bif.slave_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_t22 got %b want 1", bif.slave_ready); end
    read_word(12'h001, d, nb, fi, ia);
    n_checks++; if (d !== 8'h55) begin n_fail++; $display("FAIL rd_data_001 got %h want 55", d); end
    n_checks++; if (nb !== 8) begin n_fail++; $display("FAIL rd_rvalid_count got %0d want 8", nb); end
    n_checks++; if (fi !== 2) begin n_fail++; $display("FAIL rd_first_rvalid got %0d want 2", fi); end
    n_checks++; if (ia !== 10) begin n_fail++; $display("FAIL rd_idle_offset got %0d want 10", ia); end
  endtask

  task automatic test_abort();
    logic [7:0] d; int nb, fi, ia;
    logic [11:0] a;
    a = 12'h002;
    write_word(a, 8'hAA);
    send_bit(1'b1);
    for (int i = 0; i < 5; i++) send_bit(a[i]);
    n_checks++; if (state_show !== 3'd1) begin n_fail++; $display("FAIL abort_pre_state got %0d want 1", state_show); end
    bif.bus_valid = 1'b0;
    tick();
    n_checks++; if (state_show !== 3'd0) begin n_fail++; $display("FAIL abort_state got %0d want 0", state_show); end
    n_checks++; if (bif.slave_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got %b want 1", bif.slave_ready); end
    read_word(a, d, nb, fi, ia);
    n_checks++; if (d !== 8'hAA) begin n_fail++; $display("FAIL abort_readback got %h want aa", d); end
  endtask

  task automatic test_alias();
    logic [7:0] d; int nb, fi, ia;
    write_word(12'h801, 8'h3C);
    read_word(12'h001, d, nb, fi, ia);
    n_checks++; if (d !== 8'h3C) begin n_fail++; $display("FAIL alias_data got %h want 3c", d); end
    n_checks++; if (nb !== 8) begin n_fail++; $display("FAIL alias_count got %0d want 8", nb); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d; int nb, fi, ia;
    send_bit(1'b1);
    send_addr(12'h010);
    send_data(8'h11);
    // WRITE cycle with valid still high
    tick();
    n_checks++; if (state_show !== 3'd0) begin n_fail++; $display("FAIL b2b_idle_state got %0d want 0", state_show); end
    send_bit(1'b0);
    n_checks++; if (state_show !== 3'd1) begin n_fail++; $display("FAIL b2b_mode_taken got %0d want 1", state_show); end
    send_addr(12'h010);
    read_collect(d, nb, fi, ia);
    n_checks++; if (d !== 8'h11) begin n_fail++; $display("FAIL b2b_data got %h want 11", d); end
    n_checks++; if (ia !== 10) begin n_fail++; $display("FAIL b2b_idle_offset got %0d want 10", ia); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d; int nb, fi, ia;
    write_word(12'h020, 8'h96);
    send_bit(1'b0);
    send_addr(12'h020);
    bif.bus_wdata = 1'b0;
    tick(); tick(); tick(); tick();
    // third RDATA cycle: bit 2 of 0x96 is 1
    n_checks++; if (bif.bus_rvalid !== 1'b1) begin n_fail++; $display("FAIL mid_rvalid got %b want 1", bif.bus_rvalid); end
    n_checks++; if (bif.bus_rdata !== 1'b1) begin n_fail++; $display("FAIL mid_rdata got %b want 1", bif.bus_rdata); end
    rst = 1'b1;
    #1;
    n_checks++; if (bif.bus_rvalid !== 1'b0) begin n_fail++; $display("FAIL async_rvalid got %b want 0", bif.bus_rvalid); end
    n_checks++; if (bif.bus_rdata !== 1'b0) begin n_fail++; $display("FAIL async_rdata got %b want 0", bif.bus_rdata); end
    n_checks++; if (bif.slave_ready !== 1'b1) begin n_fail++; $display("FAIL async_ready got %b want 1", bif.slave_ready); end
    n_checks++; if (state_show !== 3'd0) begin n_fail++; $display("FAIL async_state got %0d want 0", state_show); end
    bif.bus_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    // memory survives reset
    read_word(12'h001, d, nb, fi, ia);
    n_checks++; if (d !== 8'h3C) begin n_fail++; $display("FAIL post_reset_mem got %h want 3c", d); end
  endtask

  initial begin
    rst = 1'b1;
    bif.bus_valid = 1'b0;
    bif.bus_wdata = 1'b0;
    test_reset();
    test_write_read();
    test_abort();
    test_alias();
    test_back_to_back();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
